// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB4 requester: default geometry, FSM state
// encoding and a width helper used to size index and counter registers.
package apb_master_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 32'd32;
  localparam int unsigned DEF_DATA_WIDTH     = 32'd32;
  localparam int unsigned DEF_NO_OF_SLAVES   = 32'd4;
  localparam int unsigned DEF_SLAVE_SIZE     = 32'h0000_1000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/apb_master_requester_if.sv
// Command, response and APB bus signals of the requester. The master modport
// is the requester's view; the slave modport is the side that issues commands,
// consumes responses and plays the APB completer.
interface apb_master_requester_if
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned NO_OF_SLAVES = DEF_NO_OF_SLAVES
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 32'd8;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [STRB_WIDTH-1:0]   cmd_strb;
  logic [2:0]              cmd_prot;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_slverr;
  logic                    rsp_timeout;

  logic [NO_OF_SLAVES-1:0] psel;
  logic                    penable;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [STRB_WIDTH-1:0]   pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_master_addr_decoder.sv
// Maps a byte address onto one of NO_OF_SLAVES equal-sized windows.
// Slave i owns [i*SLAVE_SIZE, (i+1)*SLAVE_SIZE); anything beyond the last
// window raises decode_err with no select bit set.
module apb_master_addr_decoder
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned NO_OF_SLAVES = DEF_NO_OF_SLAVES,
  parameter int unsigned SLAVE_SIZE   = DEF_SLAVE_SIZE
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  output logic [NO_OF_SLAVES-1:0] sel,
  output logic                    decode_err
);

  logic [ADDR_WIDTH-1:0] idx_s;

  // Window index, one-hot select and out-of-range flag.
  always_comb begin
    idx_s      = addr / ADDR_WIDTH'(SLAVE_SIZE);
    sel        = {NO_OF_SLAVES{1'b0}};
    for (int i = 0; i < int'(NO_OF_SLAVES); i++) begin
      if (idx_s == ADDR_WIDTH'(i)) begin
        sel[i] = 1'b1;
      end else begin
        sel[i] = 1'b0;
      end
    end
    decode_err = (idx_s >= ADDR_WIDTH'(NO_OF_SLAVES));
  end

endmodule

// File: rtl/apb_master_requester.sv
// APB4 requester: takes one command at a time, runs SETUP/ACCESS on the
// decoded slave, waits for pready with an optional timeout and presents the
// result on a held response port until it is consumed.
module apb_master_requester
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned NO_OF_SLAVES   = DEF_NO_OF_SLAVES,
  parameter int unsigned SLAVE_SIZE     = DEF_SLAVE_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic pclk,
  input  logic preset,
  apb_master_requester_if.master bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 32'd8;
  localparam int unsigned CNT_W      = idx_width(TIMEOUT_CYCLES + 32'd1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SETUP  = ST_SETUP;
  localparam logic [1:0] ACCESS = ST_ACCESS;

  logic [1:0]              state_r;
  logic [NO_OF_SLAVES-1:0] psel_r;
  logic                    penable_r;
  logic [ADDR_WIDTH-1:0]   paddr_r;
  logic                    pwrite_r;
  logic [DATA_WIDTH-1:0]   pwdata_r;
  logic [STRB_WIDTH-1:0]   pstrb_r;
  logic [2:0]              pprot_r;
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    rsp_slverr_r;
  logic                    rsp_timeout_r;
  logic [CNT_W-1:0]        wait_cnt_r;

  logic                    cmd_ready_s;
  logic                    cmd_fire_s;
  logic [NO_OF_SLAVES-1:0] dec_sel_s;
  logic                    dec_err_s;
  logic [CNT_W-1:0]        cnt_next_s;
  logic                    timeout_hit_s;

  apb_master_addr_decoder #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .NO_OF_SLAVES (NO_OF_SLAVES),
    .SLAVE_SIZE   (SLAVE_SIZE)
  ) u_decoder (
    .addr       (bus.cmd_addr),
    .sel        (dec_sel_s),
    .decode_err (dec_err_s)
  );

  // Only accept when idle, no response is pending and not in reset.
  assign cmd_ready_s   = (state_r == IDLE) && !rsp_valid_r && !preset;
  assign cmd_fire_s    = bus.cmd_valid && cmd_ready_s;
  assign cnt_next_s    = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign timeout_hit_s = TIMEOUT_EN && (cnt_next_s == CNT_W'(TIMEOUT_CYCLES));

  // Transfer sequencing, APB output registers and response capture.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r       <= IDLE;
      psel_r        <= {NO_OF_SLAVES{1'b0}};
      penable_r     <= 1'b0;
      paddr_r       <= {ADDR_WIDTH{1'b0}};
      pwrite_r      <= 1'b0;
      pwdata_r      <= {DATA_WIDTH{1'b0}};
      pstrb_r       <= {STRB_WIDTH{1'b0}};
      pprot_r       <= 3'b000;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_slverr_r  <= 1'b0;
      rsp_timeout_r <= 1'b0;
      wait_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (rsp_valid_r && bus.rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (cmd_fire_s) begin
            if (dec_err_s) begin
              // Unmapped address: answer straight away, the bus stays quiet.
              rsp_valid_r   <= 1'b1;
              rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
              rsp_slverr_r  <= 1'b1;
              rsp_timeout_r <= 1'b0;
            end else begin
              state_r  <= SETUP;
              psel_r   <= dec_sel_s;
              paddr_r  <= bus.cmd_addr;
              pwrite_r <= bus.cmd_write;
              pwdata_r <= bus.cmd_write ? bus.cmd_wdata : {DATA_WIDTH{1'b0}};
              pstrb_r  <= bus.cmd_write ? bus.cmd_strb : {STRB_WIDTH{1'b0}};
              pprot_r  <= bus.cmd_prot;
            end
          end
        end
        SETUP: begin
          state_r    <= ACCESS;
          penable_r  <= 1'b1;
          wait_cnt_r <= {CNT_W{1'b0}};
        end
        ACCESS: begin
          if (bus.pready) begin
            // Completion beats a timeout reached in the same cycle.
            state_r       <= IDLE;
            psel_r        <= {NO_OF_SLAVES{1'b0}};
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= (!pwrite_r && !bus.pslverr) ? bus.prdata : {DATA_WIDTH{1'b0}};
            rsp_slverr_r  <= bus.pslverr;
            rsp_timeout_r <= 1'b0;
          end else if (timeout_hit_s) begin
            state_r       <= IDLE;
            psel_r        <= {NO_OF_SLAVES{1'b0}};
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_slverr_r  <= 1'b1;
            rsp_timeout_r <= 1'b1;
            wait_cnt_r    <= cnt_next_s;
          end else begin
            wait_cnt_r <= cnt_next_s;
          end
        end
        default: begin
          state_r   <= IDLE;
          psel_r    <= {NO_OF_SLAVES{1'b0}};
          penable_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_s;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_slverr  = rsp_slverr_r;
  assign bus.rsp_timeout = rsp_timeout_r;
  assign bus.psel        = psel_r;
  assign bus.penable     = penable_r;
  assign bus.paddr       = paddr_r;
  assign bus.pwrite      = pwrite_r;
  assign bus.pwdata      = pwdata_r;
  assign bus.pstrb       = pstrb_r;
  assign bus.pprot       = pprot_r;

endmodule

// File: tb/tb_apb_master_requester.sv
// Directed bench for apb_master_requester with the default geometry
// (4 slaves of 0x1000 bytes, 16-cycle timeout). Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point.
module tb_apb_master_requester;

  logic pclk;
  logic preset;
  int   n_assert;
  int   n_fail;

  apb_master_requester_if #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .NO_OF_SLAVES (4)
  ) bus ();

  apb_master_requester #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .NO_OF_SLAVES   (4),
    .SLAVE_SIZE     (32'h1000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    chk({tag, "_rsp_cleared"}, 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_strb  = 4'h0;
    bus.cmd_prot  = 3'b000;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0;
    bus.prdata    = 32'h0;
    bus.pslverr   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_psel",      64'(bus.psel),      64'd0);
    chk("rst_penable",   64'(bus.penable),   64'd0);
    chk("rst_paddr",     64'(bus.paddr),     64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    preset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Zero-wait write to slave 1; pready high already in SETUP is ignored
    send_cmd(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = 32'h0;
    bus.pready    = 1'b1;
    chk("wr_setup_psel",    64'(bus.psel),      64'h2);
    chk("wr_setup_penable", 64'(bus.penable),   64'd0);
    chk("wr_setup_paddr",   64'(bus.paddr),     64'h1004);
    chk("wr_setup_pwrite",  64'(bus.pwrite),    64'd1);
    chk("wr_setup_pwdata",  64'(bus.pwdata),    64'hDEAD_BEEF);
    chk("wr_setup_pstrb",   64'(bus.pstrb),     64'hF);
    chk("wr_setup_pprot",   64'(bus.pprot),     64'h2);
    chk("wr_busy_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    tick();
    chk("wr_access_penable", 64'(bus.penable),  64'd1);
    chk("wr_access_psel",    64'(bus.psel),     64'h2);
    chk("wr_access_pwdata",  64'(bus.pwdata),   64'hDEAD_BEEF);
    chk("wr_access_rsp",     64'(bus.rsp_valid), 64'd0);
    tick();
    bus.pready = 1'b0;
    chk("wr_rsp_valid",   64'(bus.rsp_valid),   64'd1);
    chk("wr_rsp_slverr",  64'(bus.rsp_slverr),  64'd0);
    chk("wr_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    chk("wr_rsp_rdata",   64'(bus.rsp_rdata),   64'd0);
    chk("wr_done_psel",   64'(bus.psel),        64'd0);
    chk("wr_done_penable", 64'(bus.penable),    64'd0);
    handshake("wr");
    chk("wr_after_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Read from slave 2 with three wait states
    send_cmd(1'b0, 32'h0000_2008, 32'hAAAA_5555, 4'hF, 3'b001);
    bus.prdata = 32'hFFFF_0000;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rd_setup_psel",   64'(bus.psel),   64'h4);
    chk("rd_setup_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rd_setup_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rd_setup_pstrb",  64'(bus.pstrb),  64'd0);
    tick();
    tick();
    chk("rd_wait_penable", 64'(bus.penable),   64'd1);
    chk("rd_wait_paddr",   64'(bus.paddr),     64'h2008);
    chk("rd_wait_rsp",     64'(bus.rsp_valid), 64'd0);
    tick();
    tick();
    chk("rd_wait3_psel",  64'(bus.psel),      64'h4);
    chk("rd_wait3_pstrb", 64'(bus.pstrb),     64'd0);
    chk("rd_wait3_rsp",   64'(bus.rsp_valid), 64'd0);
    bus.pready = 1'b1;
    bus.prdata = 32'h1234_5678;
    tick();
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    chk("rd_rsp_valid",  64'(bus.rsp_valid),  64'd1);
    chk("rd_rsp_rdata",  64'(bus.rsp_rdata),  64'h1234_5678);
    chk("rd_rsp_slverr", 64'(bus.rsp_slverr), 64'd0);
    chk("rd_done_psel",  64'(bus.psel),       64'd0);
    handshake("rd");

    // Unmapped address: immediate error, no select
    send_cmd(1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    chk("dec_rsp_valid",  64'(bus.rsp_valid),  64'd1);
    chk("dec_rsp_slverr", 64'(bus.rsp_slverr), 64'd1);
    chk("dec_rsp_rdata",  64'(bus.rsp_rdata),  64'd0);
    chk("dec_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    chk("dec_psel",       64'(bus.psel),       64'd0);
    tick();
    chk("dec_psel_later", 64'(bus.psel),       64'd0);
    chk("dec_rsp_held",   64'(bus.rsp_valid),  64'd1);
    handshake("dec");

    // Last word of slave 3 answered with pslverr
    send_cmd(1'b0, 32'h0000_3FFC, 32'h0, 4'h0, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    chk("err_setup_psel", 64'(bus.psel), 64'h8);
    tick();
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hCAFE_F00D;
    tick();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    chk("err_rsp_valid",  64'(bus.rsp_valid),  64'd1);
    chk("err_rsp_slverr", 64'(bus.rsp_slverr), 64'd1);
    chk("err_rsp_rdata",  64'(bus.rsp_rdata),  64'd0);
    handshake("err");

    // Timeout: pready low for 16 ACCESS cycles on slave 0
    send_cmd(1'b1, 32'h0000_0000, 32'h1111_2222, 4'h3, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    chk("to_setup_psel", 64'(bus.psel), 64'h1);
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_still_access", 64'(bus.penable), 64'd1);
    end
    tick();
    chk("to_psel",        64'(bus.psel),        64'd0);
    chk("to_penable",     64'(bus.penable),     64'd0);
    chk("to_rsp_valid",   64'(bus.rsp_valid),   64'd1);
    chk("to_rsp_slverr",  64'(bus.rsp_slverr),  64'd1);
    chk("to_rsp_timeout", 64'(bus.rsp_timeout), 64'd1);
    chk("to_rsp_rdata",   64'(bus.rsp_rdata),   64'd0);
    handshake("to");

    // pready on the 16th ACCESS cycle completes normally
    send_cmd(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("p16_still_access", 64'(bus.penable), 64'd1);
    bus.pready = 1'b1;
    bus.prdata = 32'h0BAD_CAFE;
    tick();
    bus.pready = 1'b0;
    chk("p16_rsp_valid",   64'(bus.rsp_valid),   64'd1);
    chk("p16_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    chk("p16_rsp_slverr",  64'(bus.rsp_slverr),  64'd0);
    chk("p16_rsp_rdata",   64'(bus.rsp_rdata),   64'h0BAD_CAFE);
    handshake("p16");

    // Response backpressure with a new command waiting
    send_cmd(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.pready = 1'b1;
    bus.prdata = 32'h55AA_33CC;
    tick();
    bus.pready = 1'b0;
    bus.prdata = 32'h9999_9999;
    send_cmd(1'b1, 32'h0000_1010, 32'h7777_8888, 4'hC, 3'b100);
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_rsp_rdata", 64'(bus.rsp_rdata), 64'h55AA_33CC);
      chk("bp_psel",      64'(bus.psel),      64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_rsp_cleared", 64'(bus.rsp_valid), 64'd0);
    chk("bp_cmd_ready_up", 64'(bus.cmd_ready), 64'd1);
    chk("bp_not_yet_sel", 64'(bus.psel),      64'd0);
    tick();
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b1;
    chk("bp_new_psel",  64'(bus.psel),   64'h2);
    chk("bp_new_paddr", 64'(bus.paddr),  64'h1010);
    chk("bp_new_pstrb", 64'(bus.pstrb),  64'hC);
    tick();
    tick();
    bus.pready = 1'b0;
    chk("bp_new_rsp", 64'(bus.rsp_valid), 64'd1);
    handshake("bp");

    // Reset during ACCESS of a write, with pready arriving at the reset edge
    send_cmd(1'b1, 32'h0000_2000, 32'h1357_9BDF, 4'hF, 3'b111);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("mr_in_access", 64'(bus.penable), 64'd1);
    preset     = 1'b1;
    bus.pready = 1'b1;
    tick();
    chk("mr_psel",      64'(bus.psel),      64'd0);
    chk("mr_penable",   64'(bus.penable),   64'd0);
    chk("mr_paddr",     64'(bus.paddr),     64'd0);
    chk("mr_pwrite",    64'(bus.pwrite),    64'd0);
    chk("mr_pwdata",    64'(bus.pwdata),    64'd0);
    chk("mr_pstrb",     64'(bus.pstrb),     64'd0);
    chk("mr_pprot",     64'(bus.pprot),     64'd0);
    chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mr_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    preset     = 1'b0;
    bus.pready = 1'b0;
    tick();
    chk("mr_after_rsp",       64'(bus.rsp_valid), 64'd0);
    chk("mr_after_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    send_cmd(1'b1, 32'h0000_3000, 32'h2468_ACE0, 4'h5, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b1;
    chk("mr_next_psel",   64'(bus.psel),   64'h8);
    chk("mr_next_pwdata", 64'(bus.pwdata), 64'h2468_ACE0);
    tick();
    chk("mr_next_penable", 64'(bus.penable), 64'd1);
    tick();
    bus.pready = 1'b0;
    chk("mr_next_rsp",    64'(bus.rsp_valid),  64'd1);
    chk("mr_next_slverr", 64'(bus.rsp_slverr), 64'd0);
    handshake("mr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
